// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: FSM state encoding and default debounce length shared by the debouncer.
package btn_debounce_pkg;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
endpackage

// File: rtl/btn_debounce_sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous input into the clock domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_chain <= '0;
    else r_chain <= {r_chain[STAGES-2:0], d};
  assign q = r_chain[STAGES-1];
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces a pushbutton, emitting one enable pulse per accepted press.
// Define BTN_DEBOUNCE_TOGGLE_EN to build the press-toggled enable_toggle flop; otherwise it is tied 0.
import btn_debounce_pkg::*;
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic enable,
  output logic btn_level,
  output logic enable_toggle
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic w_sync;
  logic w_fire;
  logic [CW-1:0] w_cnt_next;
  state_t w_next;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_enable;
  logic r_level;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (btn_in),
    .q    (w_sync)
  );
  always_comb begin
    w_next = r_state;
    w_fire = 1'b0;
    case (r_state)
      IDLE:         w_next = w_sync ? PRESS_WAIT : IDLE;
      PRESS_WAIT:   begin
        w_next = !w_sync ? IDLE : (r_cnt == CNT_MAX) ? PRESSED : PRESS_WAIT;
        w_fire = w_sync && (r_cnt == CNT_MAX);
      end
      PRESSED:      w_next = w_sync ? PRESSED : RELEASE_WAIT;
      RELEASE_WAIT: w_next = w_sync ? PRESSED : (r_cnt == CNT_MAX) ? IDLE : RELEASE_WAIT;
      default:      w_next = IDLE;
    endcase
    // every state change restarts the count, so it can never wrap
    w_cnt_next = (w_next != r_state) ? '0 : r_cnt + CW'(1);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_enable <= 1'b0;
      r_level  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= (w_next == PRESS_WAIT || w_next == RELEASE_WAIT) ? w_cnt_next : '0;
      r_enable <= w_fire;
      r_level  <= (w_next == PRESSED) || (w_next == RELEASE_WAIT);
    end
  assign enable    = r_enable;
  assign btn_level = r_level;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
  logic r_toggle;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_toggle <= 1'b0;
    else if (r_enable) r_toggle <= ~r_toggle;
  assign enable_toggle = r_toggle;
`else
  assign enable_toggle = 1'b0;
`endif
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed stimulus pushes expected pulse cycles; a negedge monitor pops and checks them.
module tb_btn_debounce;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic enable, btn_level, enable_toggle;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit model_tog = 1'b0;
  typedef struct {int at; bit tog;} exp_t;
  exp_t exp_q[$];
  bit tog_pending = 1'b0;
  bit tog_exp = 1'b0;

  btn_debounce #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_in       (btn_in),
    .enable       (enable),
    .btn_level    (btn_level),
    .enable_toggle(enable_toggle)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (tog_pending) begin
      checks++;
      if (enable_toggle !== tog_exp) begin
        errors++;
        $display("FAIL toggle cyc=%0d got=%b want=%b", cyc, enable_toggle, tog_exp);
      end
      tog_pending = 1'b0;
    end
    if (enable === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse unexpected cyc=%0d want=none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.at) begin
          errors++;
          $display("FAIL pulse_cycle got=%0d want=%0d", cyc, e.at);
        end
        tog_pending = 1'b1;
        tog_exp = e.tog;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_pulse(input int at);
    exp_t e;
`ifdef BTN_DEBOUNCE_TOGGLE_EN
    model_tog = ~model_tog;
`endif
    e.at = at;
    e.tog = model_tog;
    exp_q.push_back(e);
  endtask

  task automatic clean_press(input int hold, input int gap);
    btn_in = 1'b1;
    expect_pulse(cyc + 7);
    tick(hold);
    btn_in = 1'b0;
    tick(gap);
  endtask

  initial begin
    int c, p0;
    tick(3);
    chk("rst_enable", enable, 1'b0);
    chk("rst_level", btn_level, 1'b0);
    chk("rst_toggle", enable_toggle, 1'b0);
    reset = 1'b1;
    tick(3);
    // clean press and release
    btn_in = 1'b1;
    c = cyc;
    expect_pulse(c + 7);
    tick(6);
    chk("press_level_before", btn_level, 1'b0);
    tick(1);
    chk("press_level_after", btn_level, 1'b1);
    tick(13);
    btn_in = 1'b0;
    tick(6);
    chk("release_level_before", btn_level, 1'b1);
    tick(1);
    chk("release_level_after", btn_level, 1'b0);
    tick(5);
    // bounce: 20 ns toggles then held high
    for (int i = 0; i < 4; i++) begin
      btn_in = ~btn_in;
      tick(2);
    end
    btn_in = 1'b1;
    expect_pulse(cyc + 7);
    tick(15);
    chk("bounce_level", btn_level, 1'b1);
    btn_in = 1'b0;
    tick(10);
    // glitch: 30 ns high
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("glitch_level", btn_level, 1'b0);
      tick(1);
    end
    // reset during PRESS_WAIT, button held through deassertion
    btn_in = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    chk("midrst_enable", enable, 1'b0);
    chk("midrst_level", btn_level, 1'b0);
    chk("midrst_toggle", enable_toggle, 1'b0);
    model_tog = 1'b0;
    tick(3);
    reset = 1'b1;
    expect_pulse(cyc + 7);
    tick(6);
    chk("midrst_level_before", btn_level, 1'b0);
    tick(1);
    chk("midrst_level_after", btn_level, 1'b1);
    tick(5);
    btn_in = 1'b0;
    tick(10);
    // five clean presses feed a pulse counter
    p0 = pulses;
    for (int i = 0; i < 5; i++) clean_press(10, 10);
    checks++;
    if (pulses - p0 != 5) begin
      errors++;
      $display("FAIL counter_five got=%0d want=5", pulses - p0);
    end
    // held button: exactly one count
    p0 = pulses;
    clean_press(60, 10);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL counter_held got=%0d want=1", pulses - p0);
    end
    tick(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive stable synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth; legal range 2..4.
REQ-003 Port clock, input, 1 bit, SHALL be the single clock; all flops are rising-edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port btn_in, input, 1 bit, SHALL be the raw, asynchronous, bouncing pushbutton (1 = pressed).
REQ-006 Port enable, output, 1 bit, SHALL be a one-cycle pulse per accepted press; it directly drives the counter's enable input.
REQ-007 Port btn_level, output, 1 bit, SHALL be the debounced button level.
REQ-008 Port enable_toggle, output, 1 bit, SHALL be a press-toggled run/stop level (see Configuration).

Function
REQ-009 btn_in SHALL pass through a SYNC_STAGES-deep flop chain; btn_sync is the last stage, and no logic other than the chain SHALL read btn_in.
REQ-010 The FSM SHALL have four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011 IDLE: btn_sync=1 SHALL go to PRESS_WAIT and clear cnt to 0; otherwise the FSM SHALL stay in IDLE.
REQ-012 PRESS_WAIT: btn_sync=0 SHALL return to IDLE (bounce rejected, no pulse).
REQ-013 PRESS_WAIT: btn_sync=1 with cnt=DEBOUNCE_CYCLES-1 SHALL go to PRESSED; with btn_sync=1 and any smaller cnt, cnt SHALL increment.
REQ-014 PRESSED: btn_sync=0 SHALL go to RELEASE_WAIT and clear cnt to 0.
REQ-015 RELEASE_WAIT: btn_sync=1 SHALL return to PRESSED with no new pulse.
REQ-016 RELEASE_WAIT: btn_sync=0 with cnt=DEBOUNCE_CYCLES-1 SHALL go to IDLE; with btn_sync=0 and any smaller cnt, cnt SHALL increment.
REQ-017 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never wrap, because it is cleared on every state entry.
REQ-018 btn_level SHALL be registered and SHALL be 1 exactly when the state is PRESSED or RELEASE_WAIT.
REQ-019 enable SHALL be registered and SHALL be 1 for exactly the first cycle the FSM is in PRESSED after a PRESS_WAIT→PRESSED transition, and only then.
REQ-020 Latency: with SYNC_STAGES=2, a clean rise settling before clock edge 1 SHALL raise enable and btn_level after edge DEBOUNCE_CYCLES+3.
REQ-021 A held button SHALL produce exactly one pulse, with no auto-repeat.
REQ-022 An input pulse or glitch no longer than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no change on btn_level.

Reset
REQ-023 reset=0 SHALL immediately force all synchronizer flops to 0, the state to IDLE, cnt to 0, and enable, btn_level and enable_toggle to 0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort the operation without emitting any pulse.
REQ-025 A button held across reset deassertion SHALL be treated as a new press: one pulse after the full debounce latency.

Configuration
REQ-026 Macro BTN_DEBOUNCE_TOGGLE_EN defined: enable_toggle SHALL invert on every cycle in which enable=1, and SHALL be 0 after reset.
REQ-027 Macro BTN_DEBOUNCE_TOGGLE_EN undefined: enable_toggle SHALL be tied to constant 0, and no toggle flop SHALL be synthesized.

Structure
REQ-028 Package btn_debounce_pkg SHALL hold the FSM state typedef (2-bit enum) and the constant DEBOUNCE_CYCLES_DEFAULT=16.
REQ-029 The synchronizer SHALL be the sub-module sync_ff, with parameter STAGES, ports clock, reset, d, q, and async active-low reset to 0.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10 ns clock)
REQ-030 Clean press: btn_in 0→1 held 200 ns -> one enable pulse after edge 7 and btn_level=1; release -> btn_level=0 after 7 edges, with no pulse.
REQ-031 Bounce: btn_in toggling every 20 ns for 100 ns, then held 1 -> exactly one enable pulse, occurring 7 edges after the final rise.
REQ-032 Glitch: btn_in high for 30 ns -> enable and btn_level stay 0 throughout.
REQ-033 Reset mid-operation: reset=0 asserted while in PRESS_WAIT -> all outputs 0 at once; button held at release -> one pulse 7 edges after reset deasserts.
REQ-034 Toggle, with BTN_DEBOUNCE_TOGGLE_EN defined: three clean presses -> enable_toggle goes 1, 0, 1; with the macro undefined -> enable_toggle is 0 throughout.
REQ-035 Chained with the counter: five clean presses -> counter_out=5; a held button -> counter_out advances by exactly 1.
